// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer controller with in-order retirement.
//   Entries are allocated at the tail, completed out of order through the
//   CDB, and retired from the head one per cycle once done.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   alloc_valid/alloc_rd         - dispatch request and destination register
//   alloc_ready/alloc_tag        - entry available, tag granted (tail)
//   cdb_valid/cdb_tag/cdb_value  - completion broadcast
//   commit_valid/commit_ready    - head retirable / register file accepts
//   commit_tag/rd/value          - head entry contents
//   flush                        - discard all entries
//   count/full/empty             - occupancy status
// Configuration:
//   QU_ROB_CDB_FWD_EN - when defined, a completion to a pending head entry is
//   forwarded so the head can retire in the same cycle it completes.
module rob_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid,
  input  logic [4:0]    alloc_rd,
  output logic          alloc_ready,
  output logic [AW-1:0] alloc_tag,
  input  logic          cdb_valid,
  input  logic [AW-1:0] cdb_tag,
  input  logic [DW-1:0] cdb_value,
  output logic          commit_valid,
  input  logic          commit_ready,
  output logic [AW-1:0] commit_tag,
  output logic [4:0]    commit_rd,
  output logic [DW-1:0] commit_value,
  input  logic          flush,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned RW = 5;

  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [RW-1:0]    r_rd    [DEPTH];
  logic [DW-1:0]    r_value [DEPTH];

  logic w_alloc;
  logic w_cpl;
  logic w_commit;
  logic w_fwd;

  // Status and allocation outputs come straight from state.
  assign full        = (r_count == (AW+1)'(DEPTH));
  assign empty       = (r_count == '0);
  assign alloc_ready = !full;
  assign alloc_tag   = r_tail;
  assign count       = r_count;

  // Head forwarding: a completion to the still-pending head makes it retirable now.
`ifdef QU_ROB_CDB_FWD_EN
  assign w_fwd = cdb_valid && (cdb_tag == r_head) && r_valid[r_head] && !r_done[r_head];
`else
  assign w_fwd = 1'b0;
`endif

  assign commit_valid = !empty && (r_done[r_head] || w_fwd);
  assign commit_tag   = r_head;
  assign commit_rd    = r_rd[r_head];
  assign commit_value = w_fwd ? cdb_value : r_value[r_head];

  // Handshakes; a flush cycle suppresses the commit.
  assign w_alloc  = alloc_valid && alloc_ready;
  assign w_cpl    = cdb_valid && r_valid[cdb_tag];
  assign w_commit = commit_valid && commit_ready && !flush;

  // Entry and pointer state. The commit clear is ordered last so it wins
  // over a completion landing on the head in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rd[i]    <= '0;
        r_value[i] <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_cpl) begin
        r_done[cdb_tag]  <= 1'b1;
        r_value[cdb_tag] <= cdb_value;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_rd[r_tail]    <= alloc_rd;
        r_tail          <= r_tail + AW'(1);
      end
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + AW'(1);
      end
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed and randomized checks of rob_ctrl against a
// queue-based model of the in-flight instruction window.
module tb_rob_ctrl;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        commit_valid;
  logic        commit_ready;
  logic [2:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic        flush;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  rob_ctrl #(.DEPTH(8), .AW(3), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_tag(commit_tag), .commit_rd(commit_rd), .commit_value(commit_value),
    .flush(flush), .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: in-flight instructions in program order.
  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  rd;
    logic        done;
    logic [31:0] value;
  } ent_t;

  ent_t q[$];
  int   m_tail = 0;

  logic [3:0]  e_count;
  logic        e_full, e_empty, e_ready, e_cv;
  logic [2:0]  e_atag, e_ctag;
  logic [4:0]  e_crd;
  logic [31:0] e_cval;

  task automatic model_eval();
    e_count = 4'(q.size());
    e_full  = (q.size() == DEPTH);
    e_empty = (q.size() == 0);
    e_ready = !e_full;
    e_atag  = 3'(m_tail);
    e_cv    = 1'b0;
    e_ctag  = 3'(m_tail);
    e_crd   = '0;
    e_cval  = '0;
    if (q.size() > 0) begin
      e_cv   = q[0].done;
      e_ctag = q[0].tag;
      e_crd  = q[0].rd;
      e_cval = q[0].value;
`ifdef QU_ROB_CDB_FWD_EN
      if (cdb_valid && cdb_tag == q[0].tag && !q[0].done) begin
        e_cv   = 1'b1;
        e_cval = cdb_value;
      end
`endif
    end
  endtask

  task automatic model_update();
    bit do_alloc, do_commit;
    model_eval();
    if (rst || flush) begin
      q.delete();
      m_tail = 0;
    end else begin
      do_alloc  = alloc_valid && (q.size() < DEPTH);
      do_commit = e_cv && commit_ready;
      if (cdb_valid)
        foreach (q[i])
          if (q[i].tag == cdb_tag) begin
            q[i].done  = 1'b1;
            q[i].value = cdb_value;
          end
      if (do_commit) void'(q.pop_front());
      if (do_alloc) begin
        q.push_back('{tag: 3'(m_tail), rd: alloc_rd, done: 1'b0, value: 32'h0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  // Advance one clock; leaves time at posedge+1 for driving the next cycle.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; alloc_valid = 1'b0; alloc_rd = '0; cdb_valid = 1'b0;
    cdb_tag = '0; cdb_value = '0; commit_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; flush = 1'b1; alloc_valid = 1'b1; commit_ready = 1'b1;
    step(); step();
    idle();
    #1;
    n_total++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready); else n_pass++;
    n_total++; if (alloc_tag !== 3'd0) $display("FAIL reset_alloc_tag got %0d exp 0", alloc_tag); else n_pass++;
    n_total++; if (commit_valid !== 1'b0) $display("FAIL reset_commit_valid got %b exp 0", commit_valid); else n_pass++;
    n_total++; if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_empty_full got %b%b exp 10", empty, full); else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      idle(); alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
      #1;
      n_total++; if (alloc_tag !== 3'(i)) $display("FAIL fill_tag got %0d exp %0d", alloc_tag, i); else n_pass++;
      step();
    end
    idle(); #1;
    n_total++; if (full !== 1'b1 || alloc_ready !== 1'b0) $display("FAIL fill_full got full=%b ready=%b exp 1/0", full, alloc_ready); else n_pass++;
    n_total++; if (count !== 4'd8) $display("FAIL fill_count got %0d exp 8", count); else n_pass++;
  endtask

  task automatic test_ooo_complete();
    logic [31:0] vals [3];
    int k0;
    vals[0] = 32'h00; vals[1] = 32'h11; vals[2] = 32'h22;
    k0 = 0;
    for (int t = 2; t >= 0; t--) begin
      idle(); commit_ready = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'(t); cdb_value = vals[t];
      #1;
      if (t != 0) begin
        n_total++; if (commit_valid !== 1'b0) $display("FAIL ooo_early_commit tag %0d got %b exp 0", t, commit_valid); else n_pass++;
      end else begin
`ifdef QU_ROB_CDB_FWD_EN
        n_total++; if (commit_valid !== 1'b1 || commit_tag !== 3'd0 || commit_value !== 32'h0)
          $display("FAIL ooo_fwd got v=%b tag=%0d val=%h exp 1/0/0", commit_valid, commit_tag, commit_value); else n_pass++;
        k0 = 1;
`else
        n_total++; if (commit_valid !== 1'b0) $display("FAIL ooo_nofwd got %b exp 0", commit_valid); else n_pass++;
`endif
      end
      step();
    end
    idle(); commit_ready = 1'b1;
    for (int k = k0; k < 3; k++) begin
      int waited = 0;
      #1;
      while (!commit_valid && waited < 4) begin step(); waited++; end
      n_total++; if (commit_valid !== 1'b1) $display("FAIL ooo_commit_timeout k=%0d got %b exp 1", k, commit_valid); else n_pass++;
      n_total++; if (commit_tag !== 3'(k) || commit_value !== vals[k] || commit_rd !== 5'(k + 1))
        $display("FAIL ooo_commit_order got tag=%0d val=%h rd=%0d exp %0d/%h/%0d", commit_tag, commit_value, commit_rd, k, vals[k], k + 1); else n_pass++;
      step();
    end
    idle(); #1;
    n_total++; if (count !== 4'd5) $display("FAIL ooo_count got %0d exp 5", count); else n_pass++;
  endtask

  task automatic test_cdb_head();
    idle(); commit_ready = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_value = 32'hAB;
    #1;
`ifdef QU_ROB_CDB_FWD_EN
    n_total++; if (commit_valid !== 1'b1 || commit_value !== 32'hAB) $display("FAIL head_fwd got v=%b val=%h exp 1/ab", commit_valid, commit_value); else n_pass++;
`else
    n_total++; if (commit_valid !== 1'b0) $display("FAIL head_nofwd_same got %b exp 0", commit_valid); else n_pass++;
`endif
    step();
    idle(); commit_ready = 1'b1; #1;
`ifdef QU_ROB_CDB_FWD_EN
    n_total++; if (count !== 4'd4 || commit_valid !== 1'b0) $display("FAIL head_fwd_after got cnt=%0d v=%b exp 4/0", count, commit_valid); else n_pass++;
`else
    n_total++; if (commit_valid !== 1'b1 || commit_tag !== 3'd3 || commit_value !== 32'hAB)
      $display("FAIL head_nofwd_next got v=%b tag=%0d val=%h exp 1/3/ab", commit_valid, commit_tag, commit_value); else n_pass++;
`endif
    step();
    idle(); #1;
    n_total++; if (count !== 4'd4) $display("FAIL head_count got %0d exp 4", count); else n_pass++;
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 4; i++) begin
      idle(); alloc_valid = 1'b1; alloc_rd = 5'(20 + i); step();
    end
    idle(); cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_value = 32'h44; step();
    idle(); alloc_valid = 1'b1; alloc_rd = 5'd30; commit_ready = 1'b1; #1;
    n_total++; if (alloc_ready !== 1'b0 || commit_valid !== 1'b1 || commit_tag !== 3'd4 || count !== 4'd8)
      $display("FAIL stall_pre got ready=%b v=%b tag=%0d cnt=%0d exp 0/1/4/8", alloc_ready, commit_valid, commit_tag, count); else n_pass++;
    step();
    idle(); alloc_valid = 1'b1; alloc_rd = 5'd30; #1;
    n_total++; if (count !== 4'd7 || alloc_ready !== 1'b1 || alloc_tag !== 3'd4)
      $display("FAIL stall_post got cnt=%0d ready=%b tag=%0d exp 7/1/4", count, alloc_ready, alloc_tag); else n_pass++;
    step();
    idle(); #1;
    n_total++; if (count !== 4'd8 || full !== 1'b1) $display("FAIL stall_realloc got cnt=%0d full=%b exp 8/1", count, full); else n_pass++;
  endtask

  task automatic test_flush();
    idle(); flush = 1'b1; step();
    for (int i = 0; i < 5; i++) begin
      idle(); alloc_valid = 1'b1; alloc_rd = 5'(i + 3); step();
    end
    idle(); cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 32'h5; step();
    idle(); cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_value = 32'h7; step();
    idle(); flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_value = 32'h9; commit_ready = 1'b1; alloc_valid = 1'b1;
    step();
    idle(); #1;
    n_total++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) $display("FAIL flush_count got cnt=%0d empty=%b full=%b exp 0/1/0", count, empty, full); else n_pass++;
    n_total++; if (commit_valid !== 1'b0 || alloc_tag !== 3'd0) $display("FAIL flush_outs got v=%b tag=%0d exp 0/0", commit_valid, alloc_tag); else n_pass++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      idle(); alloc_valid = 1'b1; alloc_rd = 5'(i); #1;
      n_total++; if (alloc_tag !== 3'(i % 8) || count !== 4'd0 || empty !== 1'b1)
        $display("FAIL wrap_alloc i=%0d got tag=%0d cnt=%0d empty=%b exp %0d/0/1", i, alloc_tag, count, empty, i % 8); else n_pass++;
      step();
      idle(); cdb_valid = 1'b1; cdb_tag = 3'(i % 8); cdb_value = 32'(i * 3); #1;
      n_total++; if (count !== 4'd1 || empty !== 1'b0) $display("FAIL wrap_occ i=%0d got cnt=%0d empty=%b exp 1/0", i, count, empty); else n_pass++;
      step();
      idle(); commit_ready = 1'b1; #1;
      n_total++; if (commit_valid !== 1'b1 || commit_tag !== 3'(i % 8) || commit_value !== 32'(i * 3))
        $display("FAIL wrap_commit i=%0d got v=%b tag=%0d val=%h", i, commit_valid, commit_tag, commit_value); else n_pass++;
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      idle();
      rst          = ($urandom_range(0, 199) == 0);
      flush        = ($urandom_range(0, 59) == 0);
      alloc_valid  = ($urandom_range(0, 99) < 60);
      alloc_rd     = 5'($urandom);
      commit_ready = ($urandom_range(0, 99) < 65);
      cdb_valid    = ($urandom_range(0, 99) < 55);
      cdb_value    = $urandom;
      if (q.size() > 0 && $urandom_range(0, 99) < 80)
        cdb_tag = q[$urandom_range(0, q.size() - 1)].tag;
      else
        cdb_tag = 3'($urandom);
      #1;
      model_eval();
      n_total++; if (count !== e_count || full !== e_full || empty !== e_empty)
        $display("FAIL rand_status c=%0d got %0d/%b/%b exp %0d/%b/%b", c, count, full, empty, e_count, e_full, e_empty); else n_pass++;
      n_total++; if (alloc_ready !== e_ready || alloc_tag !== e_atag)
        $display("FAIL rand_alloc c=%0d got %b/%0d exp %b/%0d", c, alloc_ready, alloc_tag, e_ready, e_atag); else n_pass++;
      n_total++; if (commit_valid !== e_cv) $display("FAIL rand_commit_valid c=%0d got %b exp %b", c, commit_valid, e_cv); else n_pass++;
      if (e_cv) begin
        n_total++; if (commit_tag !== e_ctag || commit_rd !== e_crd || commit_value !== e_cval)
          $display("FAIL rand_commit_data c=%0d got %0d/%0d/%h exp %0d/%0d/%h", c, commit_tag, commit_rd, commit_value, e_ctag, e_crd, e_cval); else n_pass++;
      end
      step();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_ooo_complete();
    test_cdb_head();
    test_full_stall();
    test_flush();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rob_ctrl.md
ROB_CTRL -- requirements
Module: rob_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, number of reorder-buffer entries (power of two, at least 2).
REQ-002 The block SHALL have parameter AW, default $clog2(DEPTH), tag/pointer width.
REQ-003 The block SHALL have parameter DW, default 32, result value width.
REQ-004 The block SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port alloc_valid  in  1  dispatch requests one entry.
REQ-007 The block SHALL have port alloc_rd  in  5  destination architectural register of the dispatched instruction.
REQ-008 The block SHALL have port alloc_ready  out  1  entry available.
REQ-009 The block SHALL have port alloc_tag  out  AW  tag (tail index) granted to the current request.
REQ-010 The block SHALL have port cdb_valid  in  1  completion broadcast present.
REQ-011 The block SHALL have port cdb_tag  in  AW  tag of the completing entry.
REQ-012 The block SHALL have port cdb_value  in  DW  result value.
REQ-013 The block SHALL have port commit_valid  out  1  head entry complete and retirable.
REQ-014 The block SHALL have port commit_ready  in  1  register file accepts the commit.
REQ-015 The block SHALL have ports commit_tag  out  AW, commit_rd  out  5, and commit_value  out  DW, giving the head entry tag, destination, and value.
REQ-016 The block SHALL have port flush  in  1  discard all entries.
REQ-017 The block SHALL have ports count  out  AW+1  occupied entries, full  out  1, and empty  out  1.

Function
REQ-018 The block SHALL keep head and tail pointers of AW bits that wrap from DEPTH-1 to 0, plus an AW+1-bit occupancy count.
REQ-019 Each entry SHALL hold the valid, done, rd[4:0] and value[DW-1:0] fields.
REQ-020 The block SHALL drive full = (count == DEPTH), empty = (count == 0), alloc_ready = !full, and alloc_tag = tail, all combinationally from state.
REQ-021 An allocate SHALL occur when alloc_valid && alloc_ready; at the next edge entry[tail] gets valid=1, done=0 and rd=alloc_rd, and tail advances by 1.
REQ-022 alloc_ready SHALL NOT depend on a same-cycle commit: when full, allocation stalls even if commit fires.
REQ-023 A completion SHALL occur when cdb_valid && entry[cdb_tag].valid; at the next edge it sets done=1 and value=cdb_value.
REQ-024 A completion to an invalid entry SHALL be ignored, with no state change.
REQ-025 The block SHALL drive commit_valid = !empty && entry[head].done, with commit_tag = head, commit_rd = entry[head].rd and commit_value = entry[head].value.
REQ-026 A commit SHALL occur when commit_valid && commit_ready; at the next edge entry[head].valid and entry[head].done clear, and head advances by 1.
REQ-027 Entries SHALL retire strictly in allocation order, at most one per cycle.
REQ-028 On allocate and commit in the same cycle, count SHALL be unchanged; allocate alone gives count+1, and commit alone gives count-1.
REQ-029 A completion and a commit in the same cycle SHALL both take effect when the completion targets a non-head entry.
REQ-030 The tail entry is invalid before its allocate, so a same-cycle completion to it is ignored.
REQ-031 flush SHALL have priority over allocate, completion and commit; at the next edge head=tail=0, count=0, and every valid and done bit is 0.
REQ-032 commit_valid SHALL be ignored (treated as 0) in a flush cycle.
REQ-033 The only output latency SHALL be one cycle from completion to commit_valid; without the forwarding feature of REQ-036 there is no same-cycle forwarding.

Reset
REQ-034 On rst high at a rising edge, the block SHALL set head=0, tail=0, count=0, and all valid, done, rd and value fields to 0.
REQ-035 Rst SHALL override flush and all handshakes; after reset the outputs SHALL be alloc_ready=1, alloc_tag=0, commit_valid=0, count=0, empty=1 and full=0.

Configuration
REQ-036 With macro QU_ROB_CDB_FWD_EN defined, a cdb_valid with cdb_tag==head on a valid, not-done head SHALL assert commit_valid in the same cycle with commit_value=cdb_value; if committed that cycle, the entry retires at the edge.
REQ-037 With QU_ROB_CDB_FWD_EN undefined, commit_valid SHALL depend only on registered state, and a completion to head retires no earlier than the following cycle.

Verification
REQ-038 Reset, then allocate 8 entries with rd=1..8 -> tags 0..7, full=1, alloc_ready=0 and count=8.
REQ-039 Complete tags 2,1,0 in three consecutive cycles with values 0x22,0x11,0x00 and commit_ready=1 -> commits occur in tag order 0,1,2 with the matching values.
REQ-040 With count=8 and head done, assert alloc_valid and commit_ready together -> commit fires, no allocation that cycle, count=7, and allocation is accepted next cycle.
REQ-041 Drive the pointers through wrap by allocating and committing 20 entries -> tags go 0..7,0..7,0..3, with count and empty consistent throughout.
REQ-042 With 5 entries valid and 2 done, assert flush together with cdb_valid -> next cycle count=0, empty=1, commit_valid=0 and alloc_tag=0.
REQ-043 Complete head tag 3 with value 0xAB while commit_ready=1 -> with QU_ROB_CDB_FWD_EN defined, commit occurs in the same cycle; with it undefined, commit occurs one cycle later.
